// File: rtl/mem_read_arbiter.sv
// Two-master AXI4-Lite read-channel (AR/R) arbiter onto one shared slave port; one transaction in flight.
// Define MEM_ARB_RR_EN for round-robin arbitration; default build is fixed priority with m1 (LSU) winning.
module mem_read_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] m0_araddr,
   input  logic              m0_arvalid,
   output logic              m0_arready,
   output logic [DATA_W-1:0] m0_rdata,
   output logic [1:0]        m0_rresp,
   output logic              m0_rvalid,
   input  logic              m0_rready,
   input  logic [ADDR_W-1:0] m1_araddr,
   input  logic              m1_arvalid,
   output logic              m1_arready,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [1:0]        m1_rresp,
   output logic              m1_rvalid,
   input  logic              m1_rready,
   output logic [ADDR_W-1:0] s_araddr,
   output logic              s_arvalid,
   input  logic              s_arready,
   input  logic [DATA_W-1:0] s_rdata,
   input  logic [1:0]        s_rresp,
   input  logic              s_rvalid,
   output logic              s_rready,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_t;

   state_t state_q, state_d;
   logic   grant_q, grant_d;
   logic   winner;
   logic   rHandshake;

   assign rHandshake = (state_q == DATA) && s_rvalid && s_rready;

`ifdef MEM_ARB_RR_EN
   logic rrPtr_q, rrPtr_d;

   always_comb begin
      rrPtr_d = rrPtr_q;
      if (rHandshake) begin
         rrPtr_d = grant_q;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rrPtr_q <= 1'b0;
      end else begin
         rrPtr_q <= rrPtr_d;
      end
   end

   // Under contention the master that was not served last gets the port.
   assign winner = (m0_arvalid && m1_arvalid) ? ~rrPtr_q : m1_arvalid;
`else
   assign winner = m1_arvalid;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         grant_q <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      case (state_q)
         IDLE: begin
            if (m0_arvalid || m1_arvalid) begin
               grant_d = winner;
               state_d = ADDR;
            end
         end
         ADDR: begin
            if (s_arvalid && s_arready) begin
               state_d = DATA;
            end
         end
         DATA: begin
            if (rHandshake) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Only handshake signals are gated by ownership; address and read payload are muxed/broadcast freely.
   always_comb begin
      s_araddr   = grant_q ? m1_araddr : m0_araddr;
      s_arvalid  = 1'b0;
      s_rready   = 1'b0;
      m0_arready = 1'b0;
      m1_arready = 1'b0;
      m0_rvalid  = 1'b0;
      m1_rvalid  = 1'b0;
      case (state_q)
         ADDR: begin
            s_arvalid  = grant_q ? m1_arvalid : m0_arvalid;
            m0_arready = ~grant_q & s_arready;
            m1_arready = grant_q & s_arready;
         end
         DATA: begin
            s_rready  = grant_q ? m1_rready : m0_rready;
            m0_rvalid = ~grant_q & s_rvalid;
            m1_rvalid = grant_q & s_rvalid;
         end
         default: begin
         end
      endcase
   end

   assign m0_rdata = s_rdata;
   assign m1_rdata = s_rdata;
   assign m0_rresp = s_rresp;
   assign m1_rresp = s_rresp;
   assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Self-checking bench for mem_read_arbiter: per-cycle vector table, hand-written corner sequences,
// and an R-completion scoreboard. Expected grant order follows MEM_ARB_RR_EN when it is defined.
`timescale 1ns/1ps
module tb_mem_read_arbiter;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   logic              clock = 1'b0;
   logic              reset;
   logic [ADDR_W-1:0] m0_araddr, m1_araddr, s_araddr;
   logic              m0_arvalid, m1_arvalid, m0_arready, m1_arready;
   logic [DATA_W-1:0] m0_rdata, m1_rdata, s_rdata;
   logic [1:0]        m0_rresp, m1_rresp, s_rresp;
   logic              m0_rvalid, m1_rvalid, m0_rready, m1_rready;
   logic              s_arvalid, s_arready, s_rvalid, s_rready, busy;

   always #5 clock = ~clock;

   mem_read_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clock(clock), .reset(reset),
      .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
      .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
      .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
      .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
      .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
      .busy(busy)
   );

   typedef struct {
      logic master;
      logic [31:0] data;
      logic [1:0] resp;
   } exp_t;

   // One clock cycle of stimulus plus the outputs expected while it is applied.
   typedef struct {
      logic m0V; logic [31:0] m0A; logic m0R;
      logic m1V; logic [31:0] m1A; logic m1R;
      logic sArR; logic sRV; logic [31:0] sRD; logic [1:0] sRR;
      logic eArV; logic [31:0] eAddr; logic eM0ArR; logic eM1ArR;
      logic eM0RV; logic eM1RV; logic eSRR; logic eBusy;
      logic push; logic pM; logic [31:0] pD; logic [1:0] pR;
   } vec_t;

   exp_t expQ[$];
   vec_t vecs[$];
   int   compared = 0;
   int   mismatched = 0;
   logic expM;
   logic rrModel;

   task automatic checkBit(input string name, input logic act, input logic exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %b, want %b", name, act, exp);
      end
   endtask

   task automatic checkWord(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   task automatic scoreCompletion(input logic master, input logic [31:0] data, input logic [1:0] resp);
      exp_t e;
      compared++;
      if (expQ.size() == 0) begin
         mismatched++;
         $display("[TB] FAIL unexpected_r: got m%0d data 0x%08h, want no completion", master, data);
         return;
      end
      e = expQ.pop_front();
      if (e.master !== master || e.data !== data || e.resp !== resp) begin
         mismatched++;
         $display("[TB] FAIL r_completion: got m%0d 0x%08h resp %0d, want m%0d 0x%08h resp %0d",
                  master, data, resp, e.master, e.data, e.resp);
      end
   endtask

   // Handshakes are sampled mid-cycle; inputs only change just after the rising edge.
   always @(negedge clock) begin
      if (reset === 1'b0) begin
         if (m0_rvalid && m0_rready) scoreCompletion(1'b0, m0_rdata, m0_rresp);
         if (m1_rvalid && m1_rready) scoreCompletion(1'b1, m1_rdata, m1_rresp);
      end
   end

   task automatic applyStimulus(input vec_t v);
      m0_arvalid = v.m0V; m0_araddr = v.m0A; m0_rready = v.m0R;
      m1_arvalid = v.m1V; m1_araddr = v.m1A; m1_rready = v.m1R;
      s_arready = v.sArR; s_rvalid = v.sRV; s_rdata = v.sRD; s_rresp = v.sRR;
      if (v.push) expQ.push_back('{v.pM, v.pD, v.pR});
   endtask

   task automatic checkOutput(input int idx, input vec_t v);
      checkBit($sformatf("v%0d_s_arvalid", idx), s_arvalid, v.eArV);
      if (v.eArV) checkWord($sformatf("v%0d_s_araddr", idx), s_araddr, v.eAddr);
      checkBit($sformatf("v%0d_m0_arready", idx), m0_arready, v.eM0ArR);
      checkBit($sformatf("v%0d_m1_arready", idx), m1_arready, v.eM1ArR);
      checkBit($sformatf("v%0d_m0_rvalid", idx), m0_rvalid, v.eM0RV);
      checkBit($sformatf("v%0d_m1_rvalid", idx), m1_rvalid, v.eM1RV);
      checkBit($sformatf("v%0d_s_rready", idx), s_rready, v.eSRR);
      checkBit($sformatf("v%0d_busy", idx), busy, v.eBusy);
      checkWord($sformatf("v%0d_m0_rdata", idx), m0_rdata, v.sRD);
      checkWord($sformatf("v%0d_m1_rdata", idx), m1_rdata, v.sRD);
      checkWord($sformatf("v%0d_m0_rresp", idx), {30'd0, m0_rresp}, {30'd0, v.sRR});
      checkWord($sformatf("v%0d_m1_rresp", idx), {30'd0, m1_rresp}, {30'd0, v.sRR});
   endtask

   task automatic checkIdleOutputs(input string tag);
      checkBit({tag, "_busy"}, busy, 1'b0);
      checkBit({tag, "_s_arvalid"}, s_arvalid, 1'b0);
      checkBit({tag, "_s_rready"}, s_rready, 1'b0);
      checkBit({tag, "_m0_arready"}, m0_arready, 1'b0);
      checkBit({tag, "_m1_arready"}, m1_arready, 1'b0);
      checkBit({tag, "_m0_rvalid"}, m0_rvalid, 1'b0);
      checkBit({tag, "_m1_rvalid"}, m1_rvalid, 1'b0);
   endtask

   initial begin
      // Single fetch (m0, two slave wait cycles), m1-over-m0 contention, then an SLVERR to m1.
      vecs.push_back('{1'b1,32'h8000_0000,1'b1, 1'b0,32'h0,1'b0, 1'b1,1'b0,32'h0,2'd0, 1'b0,32'h0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,32'hDEAD_BEEF,2'd0});
      vecs.push_back('{1'b1,32'h8000_0000,1'b1, 1'b0,32'h0,1'b0, 1'b1,1'b0,32'h0,2'd0, 1'b1,32'h8000_0000,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,32'h0,2'd0});
      vecs.push_back('{1'b0,32'h0,1'b1, 1'b0,32'h0,1'b0, 1'b1,1'b0,32'h0,2'd0, 1'b0,32'h0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1, 1'b0,1'b0,32'h0,2'd0});
      vecs.push_back('{1'b0,32'h0,1'b1, 1'b0,32'h0,1'b0, 1'b1,1'b0,32'h0,2'd0, 1'b0,32'h0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1, 1'b0,1'b0,32'h0,2'd0});
      vecs.push_back('{1'b0,32'h0,1'b1, 1'b0,32'h0,1'b0, 1'b1,1'b1,32'hDEAD_BEEF,2'd0, 1'b0,32'h0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1, 1'b0,1'b0,32'h0,2'd0});
      vecs.push_back('{1'b0,32'h0,1'b1, 1'b0,32'h0,1'b0, 1'b1,1'b0,32'h0,2'd0, 1'b0,32'h0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,32'h0,2'd0});
      vecs.push_back('{1'b1,32'h100,1'b1, 1'b1,32'h200,1'b1, 1'b1,1'b0,32'h0,2'd0, 1'b0,32'h0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b1,32'h2222_2222,2'd0});
      vecs.push_back('{1'b1,32'h100,1'b1, 1'b1,32'h200,1'b1, 1'b1,1'b0,32'h0,2'd0, 1'b1,32'h200,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,32'h1111_1111,2'd0});
      vecs.push_back('{1'b1,32'h100,1'b1, 1'b0,32'h0,1'b1, 1'b1,1'b1,32'h2222_2222,2'd0, 1'b0,32'h0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1, 1'b0,1'b0,32'h0,2'd0});
      vecs.push_back('{1'b1,32'h100,1'b1, 1'b0,32'h0,1'b1, 1'b1,1'b0,32'h0,2'd0, 1'b0,32'h0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,32'h0,2'd0});
      vecs.push_back('{1'b1,32'h100,1'b1, 1'b0,32'h0,1'b1, 1'b1,1'b0,32'h0,2'd0, 1'b1,32'h100,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,32'h0,2'd0});
      vecs.push_back('{1'b0,32'h0,1'b1, 1'b0,32'h0,1'b1, 1'b1,1'b1,32'h1111_1111,2'd0, 1'b0,32'h0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1, 1'b0,1'b0,32'h0,2'd0});
      vecs.push_back('{1'b0,32'h0,1'b1, 1'b0,32'h0,1'b1, 1'b1,1'b0,32'h0,2'd0, 1'b0,32'h0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,32'h0,2'd0});
      vecs.push_back('{1'b0,32'h0,1'b1, 1'b1,32'h300,1'b1, 1'b1,1'b0,32'h0,2'd0, 1'b0,32'h0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b1,32'h3333_3333,2'd2});
      vecs.push_back('{1'b0,32'h0,1'b1, 1'b1,32'h300,1'b1, 1'b1,1'b0,32'h0,2'd0, 1'b1,32'h300,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,32'h0,2'd0});
      vecs.push_back('{1'b0,32'h0,1'b1, 1'b0,32'h0,1'b1, 1'b1,1'b1,32'h3333_3333,2'd2, 1'b0,32'h0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1, 1'b0,1'b0,32'h0,2'd0});
      vecs.push_back('{1'b0,32'h0,1'b1, 1'b0,32'h0,1'b1, 1'b1,1'b0,32'h0,2'd0, 1'b0,32'h0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,32'h0,2'd0});

      reset = 1'b1;
      m0_arvalid = 1'b0; m0_araddr = '0; m0_rready = 1'b0;
      m1_arvalid = 1'b0; m1_araddr = '0; m1_rready = 1'b0;
      s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rresp = 2'd0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      checkIdleOutputs("reset");
      @(posedge clock); #1;
      reset = 1'b0;

      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         @(negedge clock);
         checkOutput(i, vecs[i]);
         @(posedge clock); #1;
      end

      // Backpressure: AR stalled 5 cycles, then R offered while m1 withholds rready for 3 cycles.
      m0_arvalid = 1'b0; m0_rready = 1'b1;
      m1_arvalid = 1'b1; m1_araddr = 32'h0000_0400; m1_rready = 1'b0;
      s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = 32'h4444_4444; s_rresp = 2'd0;
      expQ.push_back('{1'b1, 32'h4444_4444, 2'd0});
      @(posedge clock); #1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         checkBit($sformatf("bp%0d_s_arvalid", i), s_arvalid, 1'b1);
         checkWord($sformatf("bp%0d_s_araddr", i), s_araddr, 32'h0000_0400);
         checkBit($sformatf("bp%0d_m1_arready", i), m1_arready, 1'b0);
         @(posedge clock); #1;
      end
      s_arready = 1'b1;
      @(negedge clock);
      checkBit("bp_m1_arready_go", m1_arready, 1'b1);
      @(posedge clock); #1;
      m1_arvalid = 1'b0; s_arready = 1'b0; s_rvalid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         checkBit($sformatf("bpr%0d_m1_rvalid", i), m1_rvalid, 1'b1);
         checkBit($sformatf("bpr%0d_s_rready", i), s_rready, 1'b0);
         checkBit($sformatf("bpr%0d_busy", i), busy, 1'b1);
         @(posedge clock); #1;
      end
      m1_rready = 1'b1;
      @(negedge clock);
      checkBit("bp_s_rready_go", s_rready, 1'b1);
      @(posedge clock); #1;
      s_rvalid = 1'b0;
      @(negedge clock);
      checkBit("bp_done_busy", busy, 1'b0);
      @(posedge clock); #1;

      // Reset while waiting in DATA abandons the read; a fresh m0 read must then complete.
      m0_arvalid = 1'b1; m0_araddr = 32'h0000_0500; s_arready = 1'b1;
      @(posedge clock); #1;
      @(posedge clock); #1;
      m0_arvalid = 1'b0;
      @(negedge clock);
      checkBit("rst_pre_busy", busy, 1'b1);
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      checkIdleOutputs("rst_post");
      @(posedge clock); #1;
      m0_arvalid = 1'b1; m0_araddr = 32'h0000_0600; s_rdata = 32'h6666_6666; s_rresp = 2'd1;
      expQ.push_back('{1'b0, 32'h6666_6666, 2'd1});
      @(posedge clock); #1;
      @(negedge clock);
      checkBit("rst_new_s_arvalid", s_arvalid, 1'b1);
      checkWord("rst_new_s_araddr", s_araddr, 32'h0000_0600);
      checkBit("rst_new_m0_arready", m0_arready, 1'b1);
      @(posedge clock); #1;
      m0_arvalid = 1'b0; s_rvalid = 1'b1;
      @(negedge clock);
      checkBit("rst_new_m0_rvalid", m0_rvalid, 1'b1);
      @(posedge clock); #1;
      s_rvalid = 1'b0;

      // Both masters request continuously for three rounds with a zero-wait slave.
      rrModel = 1'b0;
      m0_arvalid = 1'b1; m0_araddr = 32'h0000_0A00; m0_rready = 1'b1;
      m1_arvalid = 1'b1; m1_araddr = 32'h0000_0B00; m1_rready = 1'b1;
      s_arready = 1'b1; s_rvalid = 1'b1; s_rresp = 2'd0;
      for (int r = 0; r < 3; r++) begin
`ifdef MEM_ARB_RR_EN
         expM = ~rrModel;
`else
         expM = 1'b1;
`endif
         s_rdata = 32'hC000_0000 + 32'(r);
         expQ.push_back('{expM, 32'hC000_0000 + 32'(r), 2'd0});
         @(negedge clock);
         checkBit($sformatf("rr%0d_idle_busy", r), busy, 1'b0);
         @(posedge clock); #1;
         @(negedge clock);
         checkWord($sformatf("rr%0d_s_araddr", r), s_araddr, expM ? 32'h0000_0B00 : 32'h0000_0A00);
         checkBit($sformatf("rr%0d_m0_arready", r), m0_arready, ~expM);
         checkBit($sformatf("rr%0d_m1_arready", r), m1_arready, expM);
         @(posedge clock); #1;
         @(negedge clock);
         checkBit($sformatf("rr%0d_m0_rvalid", r), m0_rvalid, ~expM);
         checkBit($sformatf("rr%0d_m1_rvalid", r), m1_rvalid, expM);
         @(posedge clock); #1;
         rrModel = expM;
      end
      m0_arvalid = 1'b0; m1_arvalid = 1'b0; s_rvalid = 1'b0;
      @(negedge clock);
      checkBit("end_busy", busy, 1'b0);

      checkWord("scoreboard_drained", expQ.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/mem_read_arbiter.md
# mem_read_arbiter

Two-master, one-slave arbiter for the AXI4-Lite read channels (AR/R) of the core's shared memory port. Master 0 is the IFU instruction fetch; master 1 is the LSU load path out of the EXU. The winner owns the slave port from AR issue until its R handshake completes. Single-beat transfers only, one outstanding transaction at a time.

## Interface
Parameters
- ADDR_W, 32, address width
- DATA_W, 32, data width

Ports (reset is synchronous, active-high; the clock is `clock`)
- clock  in  1  clock
- reset  in  1  synchronous active-high reset
- m0_araddr / m1_araddr  in  ADDR_W  master read address
- m0_arvalid / m1_arvalid  in  1  master AR valid
- m0_arready / m1_arready  out  1  AR accepted by the slave for this master
- m0_rdata / m1_rdata  out  DATA_W  read data
- m0_rresp / m1_rresp  out  2  read response
- m0_rvalid / m1_rvalid  out  1  read data valid
- m0_rready / m1_rready  in  1  master ready for data
- s_araddr  out  ADDR_W  slave address
- s_arvalid  out  1  slave AR valid
- s_arready  in  1  slave AR ready
- s_rdata  in  DATA_W  slave read data
- s_rresp  in  2  slave read response
- s_rvalid  in  1  slave R valid
- s_rready  out  1  slave R ready
- busy  out  1  a transaction is in flight (state ≠ IDLE)

## Operation
- FSM states: IDLE, ADDR, DATA. Registered `grant` (0 = m0, 1 = m1).
- IDLE:
  - If any `mX_arvalid` is high, latch the winner into `grant` and go to ADDR next cycle.
  - All slave-side valids and all master-side ready/valid outputs are 0.
- ADDR:
  - `s_araddr` = granted master's `araddr`; `s_arvalid` = granted master's `arvalid`.
  - The granted master's `arready` = `s_arready`. The other master's `arready` = 0.
  - On `s_arvalid & s_arready`, go to DATA.
- DATA:
  - Granted master receives `rdata`, `rresp` and `rvalid` from the slave.
  - `s_rready` = granted master's `rready`. The other master sees `rvalid` = 0.
  - On `s_rvalid & s_rready`, go to IDLE.
- Masters obey AXI: once `arvalid` is asserted, it and `araddr` are held until `arready`. The arbiter does not re-check a master's `arvalid` after granting it.
- Priority with both requesting in IDLE: m1 (LSU) wins. This keeps the EXU from stalling behind speculative fetches.
- Responses pass through unmodified, including SLVERR/DECERR. No error handling is done here.
- Unused `rdata`/`rresp` outputs: drive the slave values. Only the valid/ready signals are gated.

## Timing
- Arbitration costs exactly 1 cycle: a request seen in IDLE at cycle t appears on `s_arvalid` at t+1.
- Minimum transaction length is 3 cycles (IDLE, ADDR, DATA) when the slave is zero-wait. Back-to-back transactions from either master issue every 3 cycles.
- Slave-side outputs (`s_araddr`, `s_arvalid`, `s_rready`) are combinational from the state and the granted master's inputs. There are no combinational slave-in to slave-out paths.
- Reset:
  - State is IDLE, `grant` = 0, round-robin pointer = 0, and all valid/ready outputs are 0.
  - A reset in ADDR or DATA abandons the transaction. The slave is reset by the same signal.
- A master that raises `arvalid` in the same cycle the arbiter returns to IDLE is arbitrated in that IDLE cycle. There is no extra bubble.
- No deadlock: DATA exits only on the R handshake, so masters must eventually assert `rready`.

## Configuration
- `MEM_ARB_RR_EN` defined:
  - Round-robin arbitration. A 1-bit pointer holds the last master served.
  - When both request in IDLE, the master other than the pointer wins.
  - The pointer updates to `grant` on R handshake completion.
- Undefined: fixed priority, m1 over m0, and the pointer logic is not built.

## Test plan
- Single fetch: m0 reads 0x8000_0000; slave gives AR ready at once and returns 0xDEAD_BEEF 2 cycles later. Required: m0 gets 0xDEAD_BEEF with rresp 0, m1_rvalid stays 0, `busy` high for 4 cycles.
- Simultaneous requests, fixed priority: m0 reads 0x100 and m1 reads 0x200 in the same cycle. Required: `s_araddr` = 0x200 first, then 0x100; m0 holds `arvalid` throughout with `m0_arready` = 0 until its own grant.
- Simultaneous requests, `MEM_ARB_RR_EN`: three rounds with both masters requesting continuously. Required grant order m1, m0, m1.
- Backpressure: slave holds `s_arready` low for 5 cycles, then `s_rvalid` is high while `m1_rready` is low for 3 cycles. Required: address stable for all 5 cycles, no R handshake until `rready`, FSM stays in DATA.
- Error response: slave returns rresp 2'b10 to m1. Required: m1 gets rresp 2'b10 and the arbiter returns to IDLE normally.
- Reset in DATA: assert reset for 1 cycle while waiting on `s_rvalid`. Required: next cycle IDLE, all valids 0, `busy` 0, and a new m0 request is served correctly.
